// File: rtl/pll_reconf_seq.sv
// PLL reconfiguration sequencer: reset pulse, config load strobe, settle wait,
// clock switchover, then lock qualification with timeout. One request at a time.
module pll_reconf_seq #(
    parameter int DATA_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_STABLE   = 4,
    parameter int LOCK_TIMEOUT  = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  pll_reset,
    output logic [DATA_WIDTH-1:0] pll_data,
    output logic                  pll_trigger,
    output logic                  pll_switch,
    input  logic                  pll_locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_PLL,
        S_LOAD,
        S_SETTLE,
        S_SWITCH,
        S_LOCK,
        S_DONE_OK,
        S_FAIL
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LIM  = CNT_WIDTH'(LOCK_STABLE);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(LOCK_TIMEOUT);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  stable_q, stable_d;
    logic [CNT_WIDTH-1:0]  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  stable_inc, timeout_inc;
    logic [DATA_WIDTH-1:0] pll_data_q, pll_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  pll_reset_q, pll_reset_d;
    logic                  pll_trigger_q, pll_trigger_d;
    logic                  pll_switch_q, pll_switch_d;
    logic                  sync1_q, locked_s_q;

    // pll_locked comes from the PLL's own domain, so only locked_s_q is trusted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stable_q      <= '0;
            timeout_q     <= '0;
            pll_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pll_reset_q   <= 1'b0;
            pll_trigger_q <= 1'b0;
            pll_switch_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            timeout_q     <= timeout_d;
            pll_data_q    <= pll_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pll_reset_q   <= pll_reset_d;
            pll_trigger_q <= pll_trigger_d;
            pll_switch_q  <= pll_switch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        timeout_d   = timeout_q;
        pll_data_d  = pll_data_q;
        error_d     = error_q;
        stable_inc  = locked_s_q ? (stable_q + CNT_ONE) : '0;
        timeout_inc = timeout_q + CNT_ONE;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d    = S_RESET_PLL;
                    cnt_d      = '0;
                    pll_data_d = req_data;
                    error_d    = 1'b0;
                end
            end
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SWITCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SWITCH: begin
                state_d   = S_LOCK;
                stable_d  = '0;
                timeout_d = '0;
            end
            // stable limit is tested first so a tie with the timeout counts as lock
            S_LOCK: begin
                stable_d  = stable_inc;
                timeout_d = timeout_inc;
                if (stable_inc == STABLE_LIM) begin
                    state_d = S_DONE_OK;
                end else if (timeout_inc == TIMEOUT_LIM) begin
                    state_d = S_FAIL;
                end
            end
            S_DONE_OK: state_d = S_IDLE;
            S_FAIL:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // outputs are decoded from the next state so every output leaves a flop
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE_OK) || (state_d == S_FAIL);
        pll_reset_d   = (state_d == S_RESET_PLL);
        pll_trigger_d = (state_d == S_LOAD);
        pll_switch_d  = (state_d == S_SWITCH);
        if (state_d == S_FAIL) begin
            error_d = 1'b1;
        end else if (state_d == S_DONE_OK) begin
            error_d = 1'b0;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign pll_reset   = pll_reset_q;
    assign pll_data    = pll_data_q;
    assign pll_trigger = pll_trigger_q;
    assign pll_switch  = pll_switch_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Randomised scoreboard bench for pll_reconf_seq: a lock-window model predicts
// each sequence's outcome, a negedge monitor checks every output each cycle.
module tb_pll_reconf_seq;

    localparam int DW     = 16;
    localparam int RST    = 4;
    localparam int SETTLE = 8;
    localparam int LS     = 4;
    localparam int TO     = 20;
    localparam int NSEQ   = 40;
    localparam int LOCKN  = 8192;

    typedef struct {
        int            t;
        int            dc;
        logic [DW-1:0] data;
        bit            err;
    } entry_t;

    logic          clock;
    logic          reset;
    logic          req;
    logic [DW-1:0] req_data;
    logic          busy, done, error, pll_reset, pll_trigger, pll_switch;
    logic [DW-1:0] pll_data;
    logic          pll_locked;

    entry_t        sb[$];
    bit            lockv [0:LOCKN-1];
    int            cyc;
    int            n_cmp;
    int            n_fail;
    bit            mon_en;
    bit            last_err;
    logic [DW-1:0] last_data;
    int            prev_done;
    int            poke_cyc;
    logic [DW-1:0] poke_data;
    logic [21:0]   act_v, exp_v;
    entry_t        popped;

    pll_reconf_seq #(
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (16),
        .RST_CYCLES   (RST),
        .SETTLE_CYCLES(SETTLE),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pll_reset  (pll_reset),
        .pll_data   (pll_data),
        .pll_trigger(pll_trigger),
        .pll_switch (pll_switch),
        .pll_locked (pll_locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        pll_locked = lockv[cyc];
    endtask

    // advance cycles, firing the ignored mid-sequence request pulse when scheduled
    task automatic waitUntil(input int c);
        while (cyc < c) begin
            tick();
            if (cyc == poke_cyc) begin
                req      = 1'b1;
                req_data = poke_data;
            end else begin
                req = 1'b0;
            end
        end
    endtask

    function automatic logic [21:0] expectedVector(input entry_t e, input int c);
        logic bsy, rs, tr, sw, dn, er;
        if (c <= e.t) return {5'b0, last_err, last_data};
        bsy = (c <= e.dc);
        rs  = (c >= e.t + 1) && (c <= e.t + RST);
        tr  = (c == e.t + RST + 1);
        sw  = (c == e.t + RST + SETTLE + 2);
        dn  = (c == e.dc);
        er  = (c < e.dc) ? 1'b0 : e.err;
        return {bsy, rs, tr, sw, dn, er, e.data};
    endfunction

    // mode: 0 locked, 1 never locked, 2 glitch after 3, 3 tie at limit, 4 one short, else random
    task automatic applyStimulus(input int mode, input bit held, input bit poke,
                                 input logic [DW-1:0] data, input logic [DW-1:0] pdata);
        int     t, start, lock0, kdone;
        bit     pat [1:TO];
        entry_t e;
        t     = held ? prev_done + 1 : prev_done + 1 + int'($urandom_range(0, 3));
        start = held ? prev_done - 2 : t;
        waitUntil(start);
        for (int k = 1; k <= TO; k++) begin
            case (mode)
                0:       pat[k] = 1'b1;
                1:       pat[k] = 1'b0;
                2:       pat[k] = (k != 4);
                3:       pat[k] = (k > TO - LS);
                4:       pat[k] = (k > TO - LS + 1);
                default: pat[k] = ($urandom_range(0, 3) != 0);
            endcase
        end
        kdone = 0;
        for (int k = LS; k <= TO && kdone == 0; k++) begin
            int ones;
            ones = 0;
            for (int j = k - LS + 1; j <= k; j++) ones += int'(pat[j]);
            if (ones == LS) kdone = k;
        end
        lock0  = t + RST + SETTLE + 3;
        e.t    = t;
        e.data = data;
        e.err  = (kdone == 0);
        e.dc   = lock0 + ((kdone == 0) ? TO : kdone);
        for (int k = 1; k <= TO; k++) lockv[lock0 + k - 3] = pat[k];
        sb.push_back(e);
        req      = 1'b1;
        req_data = data;
        while (cyc < t + 1) tick();
        req       = 1'b0;
        prev_done = e.dc;
        poke_cyc  = poke ? t + RST + 5 : -1;
        poke_data = pdata;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            act_v = {busy, pll_reset, pll_trigger, pll_switch, done, error, pll_data};
            if (sb.size() > 0) exp_v = expectedVector(sb[0], cyc);
            else               exp_v = {5'b0, last_err, last_data};
            checkOutput("cycle_outputs", 32'(act_v), 32'(exp_v));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("done_without_request", 32'(sb.size()), 32'd1);
                end else begin
                    popped = sb.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(popped.dc));
                    checkOutput("done_error", 32'(error), 32'(popped.err));
                    checkOutput("done_data", 32'(pll_data), 32'(popped.data));
                    last_err  = popped.err;
                    last_data = popped.data;
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        last_err   = 1'b0;
        last_data  = '0;
        poke_cyc   = -1;
        poke_data  = '0;
        cyc        = 0;
        req        = 1'b0;
        req_data   = '0;
        pll_locked = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < LOCKN; i++) lockv[i] = 1'($urandom_range(0, 1));

        repeat (3) tick();
        checkOutput("reset_state",
                    32'({busy, pll_reset, pll_trigger, pll_switch, done, error, pll_data}), 32'd0);
        tick();
        reset     = 1'b0;
        mon_en    = 1'b1;
        prev_done = cyc;

        applyStimulus(0, 1'b0, 1'b0, 16'hA5C3, 16'h0000);
        applyStimulus(1, 1'b0, 1'b0, 16'h0F0F, 16'h0000);
        applyStimulus(0, 1'b0, 1'b1, 16'h3C3C, 16'h1111);
        applyStimulus(2, 1'b1, 1'b0, 16'h2222, 16'h0000);
        applyStimulus(3, 1'b0, 1'b0, 16'h7E81, 16'h0000);
        applyStimulus(4, 1'b0, 1'b1, 16'hC001, 16'($urandom()));
        for (int s = 6; s < NSEQ; s++) begin
            applyStimulus(int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 1) == 1), 16'($urandom()), 16'($urandom()));
        end
        waitUntil(prev_done + 3);
        checkOutput("queue_drained", 32'(sb.size()), 32'd0);

        // abort a sequence with reset while pll_reset is being driven
        mon_en   = 1'b0;
        req      = 1'b1;
        req_data = 16'h5A5A;
        tick();
        req = 1'b0;
        tick();
        tick();
        checkOutput("pll_reset_before_abort", 32'({pll_reset, busy, pll_data}), {13'd0, 3'b011, 16'h5A5A});
        #2 reset = 1'b1;
        #1;
        checkOutput("async_abort",
                    32'({busy, pll_reset, pll_trigger, pll_switch, done, error, pll_data}), 32'd0);
        tick();
        tick();
        reset     = 1'b0;
        last_err  = 1'b0;
        last_data = '0;
        sb.delete();
        mon_en    = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconf_seq.md
Name: pll_reconf_seq

Overview:
- Sequences a reconfiguration of the target-clock PLL: reset, config load, trigger, switchover, then lock qualification.
- Sits between the stimulus controller, which issues a config word when a test vector block needs a new target clock, and the PLL reconfiguration pins.
- One outstanding request at a time. Reports completion and lock failure back to the requester.

Parameters:
- DATA_WIDTH, 16: width of the PLL config word (pll_data).
- CNT_WIDTH, 16: width of the internal delay, stable and timeout counters.
- RST_CYCLES, 4: cycles pll_reset is held high. Legal range 1..2^CNT_WIDTH-1.
- SETTLE_CYCLES, 8: cycles waited after the pll_trigger pulse, before pll_switch. Legal range 1..2^CNT_WIDTH-1.
- LOCK_STABLE, 4: consecutive synchronised pll_locked-high cycles required to declare lock. Must be ≥1.
- LOCK_TIMEOUT, 1000: maximum cycles spent in LOCK before failure. Must be > LOCK_STABLE.

Ports:
- clock, in, 1: single system clock.
- reset, in, 1: asynchronous, active-high reset.
- req, in, 1: start request; level-sampled only in IDLE.
- req_data, in, DATA_WIDTH: config word; captured in the cycle req is accepted.
- busy, out, 1: high from the cycle after acceptance through the DONE/FAIL cycle inclusive.
- done, out, 1: one-cycle pulse at the end of every sequence, success or fail.
- error, out, 1: set in the FAIL cycle; held until the next acceptance; cleared by reset.
- pll_reset, out, 1: PLL reset.
- pll_data, out, DATA_WIDTH: registered config word; stable from the cycle after acceptance until the next acceptance.
- pll_trigger, out, 1: one-cycle load strobe.
- pll_switch, out, 1: one-cycle clock switchover strobe.
- pll_locked, in, 1: PLL lock; asynchronous to clock.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state=IDLE; busy, done, error, pll_reset, pll_trigger and pll_switch=0; pll_data=0; all counters=0; both lock synchroniser flops=0. There is no partial-sequence recovery; the requester re-issues.
- pll_locked passes through a 2-flop synchroniser (locked_s). All FSM decisions use locked_s only.
- All outputs are registered. No combinational path from any input to any output.
- IDLE: if req=1, accept: capture pll_data<=req_data and clear error. Next state RESET_PLL with counter=0. Otherwise stay in IDLE.
- RESET_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then LOAD.
- LOAD: pll_trigger=1 for exactly one cycle, then SETTLE.
- SETTLE: all strobes low for SETTLE_CYCLES cycles, then SWITCH.
- SWITCH: pll_switch=1 for exactly one cycle, then LOCK. Entering LOCK clears the stable and timeout counters.
- LOCK, each cycle:
  - Timeout counter increments.
  - locked_s=1 increments the stable counter; locked_s=0 clears it (glitches restart qualification).
  - Stable count reaching LOCK_STABLE goes to DONE_OK.
  - Otherwise, timeout count reaching LOCK_TIMEOUT goes to FAIL.
  - If both reach their limits in the same cycle, success wins.
- DONE_OK: done=1 for one cycle, error=0, then IDLE.
- FAIL: done=1 and error=1 in the same cycle; error stays high afterwards. Then IDLE.
- req while busy=1 is ignored; there is no queueing.
- req held high through DONE is accepted on the first IDLE cycle, i.e. the cycle after the done pulse. The requester must drop req once busy is seen.
- Latency with defaults and locked_s continuously high: accept at cycle T.
  - Cycles T+1..T+4: pll_reset=1.
  - T+5: pll_trigger=1.
  - T+6..T+13: SETTLE.
  - T+14: pll_switch=1.
  - T+15..T+18: LOCK.
  - T+19: done=1.
  - General form: done at T + RST_CYCLES + SETTLE_CYCLES + LOCK_STABLE + 3.
- Strobe exclusivity: at most one of pll_reset, pll_trigger and pll_switch is high in any cycle.

Test Plan:
- Nominal: reset released, pll_locked=1 constant, req=1 for 1 cycle with req_data=16'hA5C3 at T → pll_data=A5C3 from T+1; pll_reset high T+1..T+4; trigger at T+5; switch at T+14; done=1 and error=0 at T+19; busy low at T+20.
- Timeout: pll_locked=0 constant, LOCK_TIMEOUT=20 → done=1 and error=1 exactly 20 cycles after LOCK entry; error stays 1 in IDLE; next accept clears error on the following cycle.
- Lock glitch: pll_locked drops for 1 cycle after 3 stable cycles in LOCK → stable counter restarts; done occurs ≥4 locked_s cycles after the glitch; error=0.
- Busy ignore / back-to-back: req pulses with 16'h1111 mid-SETTLE → no effect, pll_data unchanged. req held high with 16'h2222 across done → new sequence accepted the cycle after done; pll_data=2222 one cycle later.
- Reset mid-sequence: assert reset during RESET_PLL while pll_reset=1 → pll_reset, busy and pll_data go to 0 immediately (asynchronously). After release with req=0, all outputs stay 0.
- Simultaneous limits: LOCK_STABLE=4, LOCK_TIMEOUT=5, pll_locked rising so locked_s first goes high in LOCK cycle 2 → both limits reached in cycle 5 → DONE_OK with error=0.
